// File: rtl/clkout_div_bank_if.sv
// DRP-style reconfiguration port of the clock divider bank.
interface clkout_div_bank_if;
  logic        den;
  logic        dwe;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic [15:0] dout;
  logic        drdy;

  modport master (output den, dwe, daddr, di, input dout, drdy);
  modport slave  (input den, dwe, daddr, di, output dout, drdy);
endinterface

// File: rtl/clkout_div_bank.sv
// Multi-channel integer clock divider with phase offsets, lock indication
// and shadow/active reconfiguration through a DRP-style port.
module clkout_div_bank #(
  parameter int CHANNELS    = 6,
  parameter int CNT_WIDTH   = 8,
  parameter int LOCK_CYCLES = 64,
  parameter int DIVIDE_INIT = 2,
  parameter int HIGH_INIT   = 1,
  parameter int PHASE_INIT  = 0
) (
  input  logic                  clkin_i,
  input  logic                  rst_n_i,
  input  logic                  pwrdwn_i,
  clkout_div_bank_if.slave      drp,
  output logic [CHANNELS-1:0]   clkout_o,
  output logic                  locked_o
);

  localparam int LW = $clog2(LOCK_CYCLES + 1);
  typedef logic [CNT_WIDTH-1:0] cnt_t;
  typedef enum logic [1:0] {ST_RESTART, ST_COUNT, ST_LOCKED} lock_st_e;

  function automatic cnt_t clamp_div(input cnt_t v);
    return (v < cnt_t'(2)) ? cnt_t'(2) : v;
  endfunction

  function automatic cnt_t clamp_high(input cnt_t v, input cnt_t div);
    if (v == '0)  return cnt_t'(1);
    if (v >= div) return div - cnt_t'(1);
    return v;
  endfunction

  localparam cnt_t DIV_RST  = clamp_div(cnt_t'(DIVIDE_INIT));
  localparam cnt_t HIGH_RST = clamp_high(cnt_t'(HIGH_INIT), DIV_RST);
  localparam cnt_t PH_RST   = cnt_t'(PHASE_INIT);

  cnt_t sh_div_q [CHANNELS];
  cnt_t sh_high_q[CHANNELS];
  cnt_t sh_ph_q  [CHANNELS];
  cnt_t act_div_q [CHANNELS];
  cnt_t act_high_q[CHANNELS];
  cnt_t ph_q [CHANNELS];
  cnt_t cnt_q[CHANNELS];
  logic [CHANNELS-1:0] clk_q;

  lock_st_e        state_q, state_d;
  logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            pend_q, pend_d;

  logic            acc_q, we_q, drdy_q;
  logic [6:0]      addr_q;
  logic [15:0]     dout_q, rd_data;

  logic accept, commit, restart;
  logic unused_di;

  // A transaction is pending from its acceptance edge until DRDY is issued.
  assign accept  = drp.den && !acc_q;
  assign commit  = accept && drp.dwe && (drp.daddr == 7'h7F) && drp.di[0];
  assign restart = pend_q && !pwrdwn_i;
  assign unused_di = ^drp.di;

  always_ff @(posedge clkin_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sh_div_q[i]   <= DIV_RST;
        sh_high_q[i]  <= HIGH_RST;
        sh_ph_q[i]    <= PH_RST;
        act_div_q[i]  <= DIV_RST;
        act_high_q[i] <= HIGH_RST;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (accept && drp.dwe && drp.daddr[6:2] == 5'(i)) begin
          case (drp.daddr[1:0])
            2'd0:    sh_div_q[i]  <= clamp_div(drp.di[CNT_WIDTH-1:0]);
            2'd1:    sh_high_q[i] <= clamp_high(drp.di[CNT_WIDTH-1:0], sh_div_q[i]);
            2'd2:    sh_ph_q[i]   <= drp.di[CNT_WIDTH-1:0];
            default: ;
          endcase
        end
        if (restart) begin
          act_div_q[i]  <= sh_div_q[i];
          act_high_q[i] <= clamp_high(sh_high_q[i], sh_div_q[i]);
        end
      end
    end
  end

  // Channel generators: phase countdown, then HIGH cycles high within each DIVIDE period.
  always_ff @(posedge clkin_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      clk_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        ph_q[i]  <= PH_RST;
        cnt_q[i] <= '0;
      end
    end else if (pwrdwn_i) begin
      clk_q <= '0;
    end else if (restart) begin
      clk_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        ph_q[i]  <= sh_ph_q[i];
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (ph_q[i] != '0) begin
          ph_q[i] <= ph_q[i] - cnt_t'(1);
        end else begin
          clk_q[i] <= (cnt_q[i] < act_high_q[i]);
          cnt_q[i] <= (cnt_q[i] >= act_div_q[i] - cnt_t'(1)) ? '0 : cnt_q[i] + cnt_t'(1);
        end
      end
    end
  end

  always_ff @(posedge clkin_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_RESTART;
      lock_cnt_q <= '0;
      pend_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      pend_q     <= pend_d;
    end
  end

  // A commit landing on the power-down release edge merges into that restart.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    pend_d     = pwrdwn_i || (commit && !restart);
    if (pwrdwn_i) begin
      state_d = ST_RESTART;
    end else if (restart) begin
      state_d    = ST_RESTART;
      lock_cnt_d = '0;
    end else begin
      case (state_q)
        ST_RESTART, ST_COUNT: begin
          state_d    = (lock_cnt_q == LW'(LOCK_CYCLES - 1)) ? ST_LOCKED : ST_COUNT;
          lock_cnt_d = lock_cnt_q + LW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (addr_q == 7'h7F) begin
      rd_data = {15'b0, locked_o};
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (addr_q[6:2] == 5'(i)) begin
          case (addr_q[1:0])
            2'd0:    rd_data = 16'(sh_div_q[i]);
            2'd1:    rd_data = 16'(sh_high_q[i]);
            2'd2:    rd_data = 16'(sh_ph_q[i]);
            default: rd_data = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clkin_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q  <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      drdy_q <= 1'b0;
      dout_q <= '0;
    end else begin
      acc_q  <= accept;
      if (accept) begin
        addr_q <= drp.daddr;
        we_q   <= drp.dwe;
      end
      drdy_q <= acc_q;
      dout_q <= (acc_q && !we_q) ? rd_data : '0;
    end
  end

  assign drp.drdy = drdy_q;
  assign drp.dout = dout_q;
  assign clkout_o = clk_q;
  assign locked_o = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_clkout_div_bank.sv
// Scoreboard bench for clkout_div_bank: expected clocks/lock per cycle and DRP read data.
module tb_clkout_div_bank;
  localparam int CH = 6;
  localparam int LOCKC = 64;

  typedef struct packed {
    logic [CH-1:0] clk;
    logic          lk;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          pwrdwn;
  logic [CH-1:0] clkout;
  logic          locked;

  clkout_div_bank_if drp_bus();

  clkout_div_bank #(
    .CHANNELS(CH), .CNT_WIDTH(8), .LOCK_CYCLES(LOCKC),
    .DIVIDE_INIT(2), .HIGH_INIT(1), .PHASE_INIT(0)
  ) dut (
    .clkin_i (clk),
    .rst_n_i (rst_n),
    .pwrdwn_i(pwrdwn),
    .drp     (drp_bus),
    .clkout_o(clkout),
    .locked_o(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cfg_div [CH];
  int cfg_high[CH];
  int cfg_ph  [CH];
  exp_t        clk_q[$];
  logic [15:0] drp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_defaults();
    for (int i = 0; i < CH; i++) begin
      cfg_div[i] = 2; cfg_high[i] = 1; cfg_ph[i] = 0;
    end
  endtask

  function automatic exp_t expect_at(input int k);
    exp_t e;
    for (int i = 0; i < CH; i++)
      e.clk[i] = (k >= cfg_ph[i] + 1) && (((k - cfg_ph[i] - 1) % cfg_div[i]) < cfg_high[i]);
    e.lk = (k >= LOCKC);
    return e;
  endfunction

  // Called right after a restart edge (k=0); follows k=1..n.
  task automatic watch(input string tag, input int n);
    exp_t e;
    for (int k = 1; k <= n; k++) begin
      clk_q.push_back(expect_at(k));
      tick();
      e = clk_q.pop_front();
      chk($sformatf("%s_clk_k%0d", tag, k), 32'(clkout), 32'(e.clk));
      chk($sformatf("%s_lock_k%0d", tag, k), 32'(locked), 32'(e.lk));
    end
  endtask

  // Drives one DEN at edge t; returns just after edge t+1 with DRDY checked.
  task automatic drp_xfer(input string tag, input logic we, input logic [6:0] addr,
                          input logic [15:0] di, input logic [15:0] exp_do);
    drp_bus.den = 1'b1; drp_bus.dwe = we; drp_bus.daddr = addr; drp_bus.di = di;
    drp_q.push_back(exp_do);
    tick();
    drp_bus.den = 1'b0; drp_bus.dwe = 1'b0;
    tick();
    chk({tag, "_drdy"}, 32'(drp_bus.drdy), 32'd1);
    chk({tag, "_do"}, 32'(drp_bus.dout), 32'(drp_q.pop_front()));
  endtask

  initial begin
    rst_n = 1'b0; pwrdwn = 1'b0;
    drp_bus.den = 1'b0; drp_bus.dwe = 1'b0; drp_bus.daddr = '0; drp_bus.di = '0;
    cfg_defaults();
    repeat (3) tick();
    chk("rst_clkout", 32'(clkout), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_drdy", 32'(drp_bus.drdy), 32'd0);
    chk("rst_do", 32'(drp_bus.dout), 32'd0);

    // Reset defaults: period 2, first rise r+1, LOCKED at r+64.
    rst_n = 1'b1;
    tick();
    chk("r0_clkout", 32'(clkout), 32'd0);
    chk("r0_locked", 32'(locked), 32'd0);
    watch("dflt", 66);
    drp_xfer("ctrl_rd_locked", 1'b0, 7'h7F, 16'h0, 16'h0001);

    // Reconfigure channel 1 and commit.
    drp_xfer("wr_div1", 1'b1, 7'h04, 16'd5, 16'h0);
    drp_xfer("wr_high1", 1'b1, 7'h05, 16'd2, 16'h0);
    drp_xfer("wr_ph1", 1'b1, 7'h06, 16'd3, 16'h0);
    drp_xfer("rd_div1", 1'b0, 7'h04, 16'h0, 16'd5);
    drp_xfer("rd_ph1", 1'b0, 7'h06, 16'h0, 16'd3);
    drp_xfer("commit1", 1'b1, 7'h7F, 16'h1, 16'h0);
    chk("commit_lock_drop", 32'(locked), 32'd0);
    chk("commit_clk_low", 32'(clkout), 32'd0);
    cfg_div[1] = 5; cfg_high[1] = 2; cfg_ph[1] = 3;
    watch("ch1", 66);

    // Clamping on shadow write.
    drp_xfer("wr_div2_0", 1'b1, 7'h08, 16'd0, 16'h0);
    drp_xfer("rd_div2_clamp", 1'b0, 7'h08, 16'h0, 16'd2);
    drp_xfer("wr_high1_9", 1'b1, 7'h05, 16'd9, 16'h0);
    drp_xfer("rd_high1_clamp", 1'b0, 7'h05, 16'h0, 16'd4);
    drp_xfer("wr_high2_0", 1'b1, 7'h09, 16'd0, 16'h0);
    drp_xfer("rd_high2_clamp", 1'b0, 7'h09, 16'h0, 16'd1);

    // Unimplemented addresses and back-to-back DEN.
    drp_xfer("rd_reg3", 1'b0, 7'h03, 16'h0, 16'h0);
    drp_xfer("rd_ch10", 1'b0, 7'h28, 16'h0, 16'h0);
    drp_xfer("wr_ch10", 1'b1, 7'h28, 16'hFFFF, 16'h0);
    tick();
    chk("drdy_idle", 32'(drp_bus.drdy), 32'd0);
    drp_bus.den = 1'b1; drp_bus.dwe = 1'b0; drp_bus.daddr = 7'h04;
    drp_q.push_back(16'd5);
    tick();
    drp_bus.daddr = 7'h08;
    tick();
    drp_bus.den = 1'b0;
    chk("b2b_drdy", 32'(drp_bus.drdy), 32'd1);
    chk("b2b_do", 32'(drp_bus.dout), 32'(drp_q.pop_front()));
    tick();
    chk("b2b_no_drdy", 32'(drp_bus.drdy), 32'd0);
    chk("b2b_do_zero", 32'(drp_bus.dout), 32'd0);
    tick();
    chk("b2b_no_drdy2", 32'(drp_bus.drdy), 32'd0);
    chk("still_locked", 32'(locked), 32'd1);

    // Power-down while locked, commit inside it, release.
    pwrdwn = 1'b1;
    tick();
    chk("pd_clk", 32'(clkout), 32'd0);
    chk("pd_lock", 32'(locked), 32'd0);
    drp_xfer("pd_wr_div0", 1'b1, 7'h00, 16'd3, 16'h0);
    drp_xfer("pd_wr_ph0", 1'b1, 7'h02, 16'd2, 16'h0);
    drp_xfer("pd_commit", 1'b1, 7'h7F, 16'h1, 16'h0);
    drp_xfer("pd_ctrl_rd", 1'b0, 7'h7F, 16'h0, 16'h0);
    repeat (3) tick();
    chk("pd_hold_clk", 32'(clkout), 32'd0);
    chk("pd_hold_lock", 32'(locked), 32'd0);
    pwrdwn = 1'b0;
    tick();
    chk("pdrel_clk", 32'(clkout), 32'd0);
    cfg_div[0] = 3; cfg_high[0] = 1; cfg_ph[0] = 2;
    cfg_high[1] = 4;
    watch("pdrel", 70);

    // Asynchronous reset between edges, while DRDY is high.
    drp_xfer("pre_rst_rd", 1'b0, 7'h04, 16'h0, 16'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_clk", 32'(clkout), 32'd0);
    chk("arst_lock", 32'(locked), 32'd0);
    chk("arst_drdy", 32'(drp_bus.drdy), 32'd0);
    chk("arst_do", 32'(drp_bus.dout), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    cfg_defaults();
    chk("arst_r0_clk", 32'(clkout), 32'd0);
    watch("arst", 8);
    drp_xfer("arst_rd_div1", 1'b0, 7'h04, 16'h0, 16'd2);
    drp_xfer("arst_rd_high1", 1'b0, 7'h05, 16'h0, 16'd1);
    drp_xfer("arst_rd_ph0", 1'b0, 7'h02, 16'h0, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clkout_div_bank.md
# clkout_div_bank

- Multi-channel clock output generator: the fabric-synthesizable successor to the behavioural PLL model.
- Derives CHANNELS divided clocks from one input clock, each with its own integer divide, high time and phase offset.
- Provides a LOCKED indication and a working DRP-style reconfiguration port (the port the base PLL wrapper ties off).
- Sits behind the PLL model, or replaces it where only integer ratios are needed.

## Interface
- CHANNELS, 6: number of output clocks (1..31).
- CNT_WIDTH, 8: width of the divide, high and phase counters.
- LOCK_CYCLES, 64: CLKIN cycles from restart to LOCKED (≥1).
- DIVIDE_INIT, 2: reset divide value for every channel.
- HIGH_INIT, 1: reset high-time value for every channel.
- PHASE_INIT, 0: reset phase offset for every channel.
- CLKIN  in  1  sole clock; all logic on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- PWRDWN  in  1  synchronous power-down; active high.
- DEN  in  1  DRP transaction strobe.
- DWE  in  1  DRP write enable; qualified by DEN.
- DADDR  in  7  DRP address: [6:2] channel, [1:0] register.
- DI  in  16  DRP write data.
- DO  out  16  DRP read data.
- DRDY  out  1  DRP completion pulse.
- CLKOUT  out  CHANNELS  generated clocks; bit i is channel i.
- LOCKED  out  1  outputs stable and configuration active.

## Operation
- Per-channel registers, each with a shadow copy and an active copy:
  - reg 0: DIVIDE.
  - reg 1: HIGH.
  - reg 2: PHASE.
  - Each register is CNT_WIDTH bits, zero-extended on read.
- Address 0x7F is global CTRL. A write with DI[0]=1 is a commit; reads return {15'b0, LOCKED}.
- Other reg-3 addresses, and channels ≥ CHANNELS: reads return 0, writes are ignored. DRDY still pulses.
- Write clamping, applied when the shadow is stored:
  - DIVIDE<2 is stored as 2.
  - HIGH=0 is stored as 1.
  - HIGH≥DIVIDE is stored as DIVIDE-1, using the DIVIDE shadow at write time.
  - The HIGH clamp is re-applied at commit against the committed DIVIDE.
- Reads return the shadow value.
- Shadow writes do not affect running outputs until a commit.
- Restart event: reset release, commit, or PWRDWN falling. At a restart:
  - active ← shadow;
  - all CLKOUT are forced low;
  - every phase counter loads PHASE;
  - the lock counter clears;
  - LOCKED goes to 0.
- Channel run mode:
  - after the phase countdown, CLKOUT[i] is high for HIGH cycles, then low for DIVIDE-HIGH cycles, repeating;
  - the period is DIVIDE CLKIN cycles;
  - all channels share one restart, so they stay mutually phase-aligned.
- PWRDWN=1:
  - CLKOUT and LOCKED are held at 0 and all counters are frozen;
  - DRP stays operational;
  - a commit during PWRDWN updates the active registers only at PWRDWN deassertion.
- Lock FSM states:
  - RESTART → COUNT → LOCKED;
  - any restart event or PWRDWN returns the FSM to RESTART.
- DRP handshake:
  - DEN is accepted when no transaction is pending;
  - DEN during a pending transaction is ignored and produces no DRDY.
- Reset values:
  - CLKOUT=0, LOCKED=0, DRDY=0, DO=0;
  - shadow and active registers = *_INIT (clamped);
  - lock counter = 0.
- Asynchronous reset mid-operation returns everything to the reset values immediately.

## Timing
- DRP: DEN sampled at edge t, so DRDY=1 for exactly the cycle following edge t+1.
- DO is valid only while DRDY=1 and is 0 otherwise.
- A commit accepted at edge t causes its restart at edge t+1, coincident with DRDY.
- After reset release, the first CLKIN rising edge with RST_N=1 is restart edge r.
- After restart edge r:
  - CLKOUT[i] first rises at edge r+PHASE+1;
  - it then follows the HIGH/DIVIDE pattern.
- LOCKED rises at edge r+LOCK_CYCLES and stays 1 until the next restart or PWRDWN.
- PWRDWN is sampled at an edge:
  - outputs go low at that same edge;
  - at the deassertion edge d, the restart occurs with r=d.
- Commit and PWRDWN deassertion on the same edge produce a single restart using the new shadow.
- Counters wrap only within the DIVIDE period; they never overflow CNT_WIDTH.

## Test plan
- Reset defaults: release RST_N → CLKOUT[0] has period 2 and is high 1 cycle, first rise at r+1; LOCKED rises at r+64.
- Reconfigure channel 1:
  - write DIVIDE=5, HIGH=2, PHASE=3, then commit;
  - LOCKED drops at the commit edge;
  - CLKOUT[1] rises at r+4, pattern high 2 / low 3;
  - LOCKED returns at r+64.
- Clamping:
  - write DIVIDE=0 → reads back 2;
  - write HIGH=9 with DIVIDE=5 → reads back 4.
- DRP protocol:
  - a read of an unimplemented address returns 0 with a one-cycle DRDY pulse;
  - a back-to-back DEN on the next cycle is ignored, with no second DRDY.
- PWRDWN:
  - assert while locked → all CLKOUT=0 and LOCKED=0 the same edge;
  - commit during PWRDWN;
  - deassert at edge d → new configuration, first rise at d+PHASE+1.
- Async reset mid-period:
  - drop RST_N between edges → CLKOUT, LOCKED and DRDY go to 0 immediately;
  - shadow values revert to INIT.
